ad7606_seq: RTL and testbench
=============================

Name: ad7606_seq

Overview:
- Conversion sequencer for the AD7606 8-channel ADC: wake-up from standby, ADC reset, periodic CONVST and BUSY handshake, serial readout on DOUTA/DOUTB.
- Delivers parallel 16-bit samples with a valid strobe to downstream logic.
- Sits between the FPGA fabric and the ADC pins, on the ~12 MHz system clock.

Parameters:
- POWERUP_CYCLES, 2400: cycles stby is held high before the ADC reset (200 us at 12 MHz).
- RESET_CYCLES, 2: width of the ADC reset pulse, in cycles.
- CONV_PULSE, 2: cycles conv is held high.
- SAMPLE_PERIOD, 1200: cycles between conversion ticks (10 kSPS).
- BUSY_TIMEOUT, 60: maximum cycles from conv rise to busy fall.
- DATA_W, 16: bits per channel.

Ports:
- clk  in  1  system clock
- n_reset  in  1  asynchronous active-low reset
- power  in  1  enable; 1 = run, 0 = standby
- busy  in  1  ADC BUSY (asynchronous, 2-FF synchronized internally)
- douta  in  1  ADC DOUTA (channels 1-4)
- doutb  in  1  ADC DOUTB (channels 5-8)
- conv  out  1  CONVST
- n_cs  out  1  ADC chip select, active low
- sclk  out  1  serial clock, idles high
- reset  out  1  ADC RESET, active high
- stby  out  1  ADC nSTBY; 0 = standby
- sample_a  out  DATA_W  channel (sample_ch+1) word
- sample_b  out  DATA_W  channel (sample_ch+5) word
- sample_ch  out  2  channel index within line
- sample_valid  out  1  one-cycle strobe; sample_a, sample_b and sample_ch are valid
- frame_done  out  1  one-cycle strobe after the 4th channel pair
- err_timeout  out  1  sticky BUSY timeout flag
- overrun  out  1  sticky flag: tick arrived while not IDLE

Behaviour:
- Reset (n_reset=0) and power=0 force the same values, applied asynchronously by n_reset and within 1 cycle of power falling:
  - state OFF; stby=0, conv=0, n_cs=1, sclk=1, reset=0
  - sample_* = 0, strobes = 0
  - err_timeout and overrun cleared
- Any state with power=0 goes to OFF; a transfer in progress is abandoned (n_cs released, no sample_valid).
- OFF: when power=1, go to WAKE.
- WAKE: stby=1; count POWERUP_CYCLES cycles, then go to RST.
- RST: reset=1 for RESET_CYCLES cycles. On exit, go to IDLE and clear the sample timer to 0.
- Sample timer:
  - Free-runs in IDLE/CONV/BUSY/READ and wraps at SAMPLE_PERIOD-1.
  - A tick fires on the wrap; the first tick comes SAMPLE_PERIOD cycles after RST exit.
  - A tick outside IDLE sets overrun and is dropped, not queued.
- IDLE: on a tick, go to CONV.
- CONV: conv=1 for CONV_PULSE cycles, then conv=0 and go to BUSY. The timeout counter starts at the conv rise.
- BUSY: wait for synchronized busy to go 1, then 0; on the fall, go to READ.
  - If the counter reaches BUSY_TIMEOUT first: set err_timeout, go to RST (ADC re-reset), no readout.
  - A busy high/low pair faster than the 2-FF latency is not guaranteed to be seen; the timeout covers it.
- READ:
  - n_cs=0 on entry; MSB is valid from the n_cs fall.
  - sclk toggles every clk cycle: first cycle low, then high, and so on.
  - douta/doutb are shifted in on the clk edge that drives sclk 0→1.
  - 64 bits per line, 128 cycles total.
  - After every 16th bit: sample_valid=1 for one cycle with the assembled words, MSB first, sample_ch = 0..3.
  - After bit 64: sclk=1, n_cs=1, frame_done=1 for one cycle (same cycle as the ch3 sample_valid), go to IDLE.
- Busy is ignored outside BUSY. A new tick during READ sets overrun.
- err_timeout and overrun clear only via n_reset or power=0.

Test Plan:
- Overrides for all scenarios: POWERUP_CYCLES=10, RESET_CYCLES=2, SAMPLE_PERIOD=300, BUSY_TIMEOUT=60.
- Power-up: n_reset released, power 0→1 → stby=1 next cycle; reset high exactly 2 cycles after 10 cycles; first conv rise 300 cycles after reset falls.
- Normal frame: busy model rises 2 cycles after conv, falls 10 cycles later; douta streams 0x1111,0x2222,0x3333,0x4444 and doutb streams 0x5555..0x8888 → four sample_valid strobes with ch0..3 pairs (0x1111,0x5555)...(0x4444,0x8888); 64 sclk rises; n_cs low for 128 cycles; frame_done coincides with ch3.
- Timeout: busy held 0 → err_timeout=1 at cycle 60 after conv rise; reset pulses again; no sample_valid.
- Overrun: busy held high for 280 cycles with BUSY_TIMEOUT=400 → overrun=1; that tick is dropped; the next frame proceeds normally.
- Power drop mid-READ: power=0 at bit 20 → next cycle n_cs=1, sclk=1, stby=0; only ch0 sample_valid seen. Power=1 again → full WAKE/RST sequence; flags cleared.
- Async reset mid-CONV: n_reset low → conv=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/ad7606_seq.sv
// AD7606 conversion sequencer: standby wake-up, ADC reset, periodic CONVST with BUSY
// handshake, then a 64-bit dual-line serial readout delivered as channel-pair strobes.
module ad7606_seq #(
    parameter int POWERUP_CYCLES = 2400,
    parameter int RESET_CYCLES   = 2,
    parameter int CONV_PULSE     = 2,
    parameter int SAMPLE_PERIOD  = 1200,
    parameter int BUSY_TIMEOUT   = 60,
    parameter int DATA_W         = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              power,
    input  logic              busy,
    input  logic              douta,
    input  logic              doutb,
    output logic              conv,
    output logic              n_cs,
    output logic              sclk,
    output logic              reset,
    output logic              stby,
    output logic [DATA_W-1:0] sample_a,
    output logic [DATA_W-1:0] sample_b,
    output logic [1:0]        sample_ch,
    output logic              sample_valid,
    output logic              frame_done,
    output logic              err_timeout,
    output logic              overrun,
    output logic [2:0]        dbg_state
);
    localparam int CNT_MAX = (POWERUP_CYCLES > RESET_CYCLES)
                           ? ((POWERUP_CYCLES > CONV_PULSE) ? POWERUP_CYCLES : CONV_PULSE)
                           : ((RESET_CYCLES > CONV_PULSE) ? RESET_CYCLES : CONV_PULSE);
    localparam int CNT_W  = $clog2(CNT_MAX + 1);
    localparam int TMR_W  = $clog2(SAMPLE_PERIOD);
    localparam int TO_W   = $clog2(BUSY_TIMEOUT + 1);
    // DATA_W is a power of two: the read counter is {channel, bit-in-word, sclk phase}.
    localparam int DW_LG  = $clog2(DATA_W);
    localparam int RB_W   = DW_LG + 3;

    typedef enum logic [2:0] {
        S_OFF, S_WAKE, S_RST, S_IDLE, S_CONV, S_BUSY, S_READ
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [TMR_W-1:0]  r_tmr;
    logic [TO_W-1:0]   r_tcnt;
    logic [RB_W-1:0]   r_bit;
    logic [DATA_W-1:0] r_sh_a;
    logic [DATA_W-1:0] r_sh_b;
    logic              r_busy_s1;
    logic              r_busy_s2;
    logic              r_busy_seen;
    logic              w_active;
    logic              w_tick;
    logic              w_busy_fall;
    logic              w_timeout;
    logic              w_shift;
    logic              w_word_end;

    assign w_active    = (r_state == S_IDLE) || (r_state == S_CONV) ||
                         (r_state == S_BUSY) || (r_state == S_READ);
    assign w_tick      = w_active && (r_tmr == TMR_W'(SAMPLE_PERIOD - 1));
    assign w_busy_fall = (r_state == S_BUSY) && r_busy_seen && !r_busy_s2;
    assign w_timeout   = (r_state == S_BUSY) && !w_busy_fall &&
                         (r_tcnt == TO_W'(BUSY_TIMEOUT - 1));
    // Shift on the edge that takes sclk from 0 to 1 (even read cycles).
    assign w_shift     = (r_state == S_READ) && !r_bit[0];
    assign w_word_end  = w_shift && (&r_bit[DW_LG:1]);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= S_OFF;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!power) begin
            w_next = S_OFF;
        end else begin
            case (r_state)
                S_OFF:  w_next = S_WAKE;
                S_WAKE: if (r_cnt == CNT_W'(POWERUP_CYCLES - 1)) w_next = S_RST;
                S_RST:  if (r_cnt == CNT_W'(RESET_CYCLES - 1)) w_next = S_IDLE;
                S_IDLE: if (w_tick) w_next = S_CONV;
                S_CONV: if (r_cnt == CNT_W'(CONV_PULSE - 1)) w_next = S_BUSY;
                S_BUSY: begin
                    if (w_busy_fall)    w_next = S_READ;
                    else if (w_timeout) w_next = S_RST;
                end
                S_READ: if (r_bit == RB_W'(8 * DATA_W - 1)) w_next = S_IDLE;
                default: w_next = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt       <= '0;
            r_tmr       <= '0;
            r_tcnt      <= '0;
            r_bit       <= '0;
            r_sh_a      <= '0;
            r_sh_b      <= '0;
            r_busy_s1   <= 1'b0;
            r_busy_s2   <= 1'b0;
            r_busy_seen <= 1'b0;
        end else begin
            r_busy_s1 <= busy;
            r_busy_s2 <= r_busy_s1;
            if (w_next != r_state) r_cnt <= '0;
            else if ((r_state == S_WAKE) || (r_state == S_RST) || (r_state == S_CONV))
                r_cnt <= r_cnt + 1'b1;
            // Held at zero outside the running states, so it restarts from 0 on RST exit.
            if (!w_active || w_tick) r_tmr <= '0;
            else                     r_tmr <= r_tmr + 1'b1;
            if ((r_state == S_CONV) || (r_state == S_BUSY)) r_tcnt <= r_tcnt + 1'b1;
            else                                            r_tcnt <= '0;
            if (r_state != S_BUSY) r_busy_seen <= 1'b0;
            else if (r_busy_s2)    r_busy_seen <= 1'b1;
            r_bit <= (r_state == S_READ) ? r_bit + 1'b1 : '0;
            if (w_shift) begin
                r_sh_a <= {r_sh_a[DATA_W-2:0], douta};
                r_sh_b <= {r_sh_b[DATA_W-2:0], doutb};
            end
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sample_a     <= '0;
            sample_b     <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else if (!power) begin
            sample_a     <= '0;
            sample_b     <= '0;
            sample_ch    <= '0;
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            frame_done   <= 1'b0;
            if (w_word_end) begin
                sample_a     <= {r_sh_a[DATA_W-2:0], douta};
                sample_b     <= {r_sh_b[DATA_W-2:0], doutb};
                sample_ch    <= r_bit[RB_W-1:DW_LG+1];
                sample_valid <= 1'b1;
                frame_done   <= (&r_bit[RB_W-1:DW_LG+1]);
            end
            if (w_timeout)                     err_timeout <= 1'b1;
            if (w_tick && (r_state != S_IDLE)) overrun     <= 1'b1;
        end
    end

    assign conv      = (r_state == S_CONV);
    assign n_cs      = (r_state != S_READ);
    assign sclk      = (r_state == S_READ) ? r_bit[0] : 1'b1;
    assign reset     = (r_state == S_RST);
    assign stby      = (r_state != S_OFF);
    assign dbg_state = r_state;
endmodule

// File: tb/tb_ad7606_seq.sv
// Bench for ad7606_seq: ADC pin model (BUSY + serial data), scoreboard on sample strobes,
// directed scenarios for power-up, frames, timeout, overrun, power drop and async reset.
module tb_ad7606_seq;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic n_reset, power_a, power_b, busy, douta, doutb, sel;
    logic conv_a, n_cs_a, sclk_a, reset_a, stby_a, sv_a, fd_a, err_a, ovr_a;
    logic conv_b, n_cs_b, sclk_b, reset_b, stby_b, sv_b, fd_b, err_b, ovr_b;
    logic [DW-1:0] sa_a, sb_a, sa_b, sb_b;
    logic [1:0] ch_a, ch_b;
    logic [2:0] st_a, st_b;
    logic m_conv, m_n_cs, m_sclk, m_reset, m_stby, m_sv, m_fd, m_err, m_ovr;
    logic [DW-1:0] m_sa, m_sb;
    logic [1:0] m_ch;
    logic [2:0] m_st;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int busy_mode = 0;
    int rises = 0, frames = 0, last_rises = 0, last_cs = 0;
    int conv_last_cyc = 0, conv_prev_cyc = 0;
    logic [DW-1:0] data_a [4];
    logic [DW-1:0] data_b [4];
    logic [2*DW+2:0] exp_q [$];

    ad7606_seq #(.POWERUP_CYCLES(10), .RESET_CYCLES(2), .CONV_PULSE(2),
                 .SAMPLE_PERIOD(300), .BUSY_TIMEOUT(60), .DATA_W(DW)) u_dut (
        .clk(clk), .n_reset(n_reset), .power(power_a), .busy(busy), .douta(douta),
        .doutb(doutb), .conv(conv_a), .n_cs(n_cs_a), .sclk(sclk_a), .reset(reset_a),
        .stby(stby_a), .sample_a(sa_a), .sample_b(sb_a), .sample_ch(ch_a),
        .sample_valid(sv_a), .frame_done(fd_a), .err_timeout(err_a), .overrun(ovr_a),
        .dbg_state(st_a));

    ad7606_seq #(.POWERUP_CYCLES(10), .RESET_CYCLES(2), .CONV_PULSE(2),
                 .SAMPLE_PERIOD(300), .BUSY_TIMEOUT(400), .DATA_W(DW)) u_dut_ovr (
        .clk(clk), .n_reset(n_reset), .power(power_b), .busy(busy), .douta(douta),
        .doutb(doutb), .conv(conv_b), .n_cs(n_cs_b), .sclk(sclk_b), .reset(reset_b),
        .stby(stby_b), .sample_a(sa_b), .sample_b(sb_b), .sample_ch(ch_b),
        .sample_valid(sv_b), .frame_done(fd_b), .err_timeout(err_b), .overrun(ovr_b),
        .dbg_state(st_b));

    assign m_conv  = sel ? conv_b  : conv_a;
    assign m_n_cs  = sel ? n_cs_b  : n_cs_a;
    assign m_sclk  = sel ? sclk_b  : sclk_a;
    assign m_reset = sel ? reset_b : reset_a;
    assign m_stby  = sel ? stby_b  : stby_a;
    assign m_sv    = sel ? sv_b    : sv_a;
    assign m_fd    = sel ? fd_b    : fd_a;
    assign m_err   = sel ? err_b   : err_a;
    assign m_ovr   = sel ? ovr_b   : ovr_a;
    assign m_sa    = sel ? sa_b    : sa_a;
    assign m_sb    = sel ? sb_b    : sb_a;
    assign m_ch    = sel ? ch_b    : ch_a;
    assign m_st    = sel ? st_b    : st_a;

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic get_sig(input int which);
        case (which)
            0:       return m_conv;
            1:       return m_reset;
            2:       return m_n_cs;
            3:       return m_err;
            4:       return m_ovr;
            default: return m_stby;
        endcase
    endfunction

    task automatic wait_sig(input int which, input logic val, input int budget,
                            input string name, output int n);
        n = 0;
        while (get_sig(which) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (get_sig(which) !== val) begin
            checks++;
            failures++;
            $display("FAIL %s: no event within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_frame(input int f_start, input int budget, input string name);
        int n;
        n = 0;
        while (frames == f_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (frames == f_start) begin
            checks++;
            failures++;
            $display("FAIL %s: frame not finished within %0d cycles", name, budget);
        end
    endtask

    task automatic set_data(input logic [DW-1:0] a0, a1, a2, a3, b0, b1, b2, b3);
        data_a[0] = a0; data_a[1] = a1; data_a[2] = a2; data_a[3] = a3;
        data_b[0] = b0; data_b[1] = b1; data_b[2] = b2; data_b[3] = b3;
    endtask

    task automatic push_exp(input int nch);
        for (int i = 0; i < nch; i++)
            exp_q.push_back({2'(i), data_a[i], data_b[i], (i == 3) ? 1'b1 : 1'b0});
    endtask

    // ADC serial model: word MSB first, next bit presented after each sclk rise
    initial begin
        logic prev_sclk;
        logic [DW-1:0] w_a, w_b;
        int cs;
        douta = 1'b0;
        doutb = 1'b0;
        prev_sclk = 1'b1;
        cs = 0;
        forever begin
            @(negedge clk);
            if (m_n_cs) begin
                if (cs > 0) begin
                    last_rises = rises;
                    last_cs = cs;
                    frames++;
                end
                rises = 0;
                cs = 0;
            end else begin
                cs++;
                if (m_sclk && !prev_sclk) rises++;
                if (rises < 4 * DW) begin
                    w_a = data_a[rises / DW];
                    w_b = data_b[rises / DW];
                    douta = w_a[DW - 1 - (rises % DW)];
                    doutb = w_b[DW - 1 - (rises % DW)];
                end
            end
            prev_sclk = m_sclk;
        end
    end

    // Conversion-start timestamps
    initial begin
        logic pc;
        pc = 1'b0;
        forever begin
            @(negedge clk);
            if (m_conv && !pc) begin
                conv_prev_cyc = conv_last_cyc;
                conv_last_cyc = cyc;
            end
            pc = m_conv;
        end
    end

    // BUSY model: 0 = normal pulse, 1 = never asserts, 2 = long pulse (280 cycles)
    initial begin
        logic pc;
        busy = 1'b0;
        pc = 1'b0;
        forever begin
            @(negedge clk);
            if (m_conv && !pc && busy_mode != 1) begin
                repeat (2) @(negedge clk);
                busy = 1'b1;
                repeat ((busy_mode == 2) ? 280 : 10) @(negedge clk);
                busy = 1'b0;
            end
            pc = m_conv;
        end
    end

    // Scoreboard monitor
    initial begin
        logic [2*DW+2:0] exp_v, act_v;
        forever begin
            @(negedge clk);
            if (m_sv) begin
                act_v = {m_ch, m_sa, m_sb, m_fd};
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sample_unexpected: got ch=%0d a=0x%h b=0x%h fd=%0b, none expected",
                             m_ch, m_sa, m_sb, m_fd);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (act_v !== exp_v) begin
                        failures++;
                        $display("FAIL sample: got ch=%0d a=0x%h b=0x%h fd=%0b expected ch=%0d a=0x%h b=0x%h fd=%0b",
                                 act_v[34:33], act_v[32:17], act_v[16:1], act_v[0],
                                 exp_v[34:33], exp_v[32:17], exp_v[16:1], exp_v[0]);
                    end
                end
            end else if (m_fd) begin
                checks++;
                failures++;
                $display("FAIL frame_done_alone: got frame_done=1 with sample_valid=0");
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

    // Directed scenarios
    initial begin
        int n, f0;
        n_reset = 1'b0; power_a = 1'b0; power_b = 1'b0; sel = 1'b0; busy_mode = 0;
        set_data(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        chk("rst_conv",  32'(m_conv),  32'(0));
        chk("rst_ncs",   32'(m_n_cs),  32'(1));
        chk("rst_sclk",  32'(m_sclk),  32'(1));
        chk("rst_reset", 32'(m_reset), 32'(0));
        chk("rst_stby",  32'(m_stby),  32'(0));
        chk("rst_valid", 32'(m_sv),    32'(0));
        chk("rst_sa",    32'(m_sa),    32'(0));
        chk("rst_err",   32'(m_err),   32'(0));
        chk("rst_ovr",   32'(m_ovr),   32'(0));
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("off_stby",  32'(m_stby),  32'(0));
        chk("off_state", 32'(m_st),    32'(0));

        // Power-up and first frame
        set_data(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
        push_exp(4);
        f0 = frames;
        power_a = 1'b1;
        @(negedge clk);
        chk("pu_stby", 32'(m_stby), 32'(1));
        wait_sig(1, 1'b1, 50, "pu_wake", n);
        chk("pu_wake_len", 32'(n), 32'(10));
        wait_sig(1, 1'b0, 10, "pu_rst", n);
        chk("pu_rst_len", 32'(n), 32'(2));
        wait_sig(0, 1'b1, 400, "pu_conv", n);
        chk("pu_first_conv", 32'(n), 32'(300));
        wait_frame(f0, 400, "frame1");
        chk("f1_sclk_rises", 32'(last_rises), 32'(64));
        chk("f1_ncs_cycles", 32'(last_cs), 32'(128));

        // Second frame with edge-case words
        set_data(16'hA5A5, 16'h0001, 16'h8000, 16'hFFFF, 16'h5A5A, 16'h7FFF, 16'hFFFE, 16'h0000);
        push_exp(4);
        f0 = frames;
        wait_frame(f0, 400, "frame2");
        chk("f2_sclk_rises", 32'(last_rises), 32'(64));
        chk("f2_period", 32'(conv_last_cyc - conv_prev_cyc), 32'(300));

        // BUSY never rises
        busy_mode = 1;
        wait_sig(0, 1'b1, 400, "to_conv", n);
        wait_sig(3, 1'b1, 100, "to_err", n);
        chk("to_cycles", 32'(n), 32'(60));
        chk("to_reset_hi", 32'(m_reset), 32'(1));
        busy_mode = 0;
        @(negedge clk);
        chk("to_reset_hi2", 32'(m_reset), 32'(1));
        @(negedge clk);
        chk("to_reset_lo", 32'(m_reset), 32'(0));
        chk("to_err_sticky", 32'(m_err), 32'(1));

        // Power drop during readout
        set_data(16'hC3C3, 16'h1234, 16'h5678, 16'h9ABC, 16'h3C3C, 16'hDEF0, 16'h0F0F, 16'hF0F0);
        push_exp(1);
        n = 0;
        while (rises < 20 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("pd_reached_bit20", 32'(rises >= 20), 32'(1));
        power_a = 1'b0;
        @(negedge clk);
        chk("pd_ncs",   32'(m_n_cs), 32'(1));
        chk("pd_sclk",  32'(m_sclk), 32'(1));
        chk("pd_stby",  32'(m_stby), 32'(0));
        chk("pd_err",   32'(m_err),  32'(0));
        chk("pd_valid", 32'(m_sv),   32'(0));
        repeat (2) @(negedge clk);
        set_data(16'h0F0F, 16'hF00F, 16'h00FF, 16'hFF00, 16'h1357, 16'h2468, 16'hACE0, 16'hBDF1);
        push_exp(4);
        power_a = 1'b1;
        @(negedge clk);
        chk("rp_stby", 32'(m_stby), 32'(1));
        wait_sig(1, 1'b1, 50, "rp_wake", n);
        chk("rp_wake_len", 32'(n), 32'(10));
        chk("rp_err_clear", 32'(m_err), 32'(0));
        wait_sig(1, 1'b0, 10, "rp_rst", n);
        chk("rp_rst_len", 32'(n), 32'(2));
        f0 = frames;
        wait_frame(f0, 500, "frame_rp");
        chk("rp_sclk_rises", 32'(last_rises), 32'(64));
        chk("rp_ncs_cycles", 32'(last_cs), 32'(128));

        // Asynchronous reset while CONVST is high
        wait_sig(0, 1'b1, 400, "ar_conv", n);
        n_reset = 1'b0;
        #1;
        chk("ar_conv_low", 32'(m_conv), 32'(0));
        chk("ar_stby_low", 32'(m_stby), 32'(0));
        power_a = 1'b0;
        @(negedge clk);
        n_reset = 1'b1;
        repeat (20) @(negedge clk);

        // Overrun: long BUSY on the instance with a 400-cycle timeout
        sel = 1'b1;
        busy_mode = 2;
        set_data(16'h2468, 16'h369C, 16'h48D0, 16'h5B04, 16'hFEDC, 16'hBA98, 16'h7654, 16'h3210);
        push_exp(4);
        @(negedge clk);
        power_b = 1'b1;
        wait_sig(0, 1'b1, 500, "ov_conv", n);
        chk("ov_first_conv", 32'(n), 32'(313));
        f0 = frames;
        wait_sig(4, 1'b1, 400, "ov_flag", n);
        chk("ov_flag_cycle", 32'(n), 32'(300));
        chk("ov_no_timeout", 32'(m_err), 32'(0));
        wait_frame(f0, 300, "ov_frame1");
        chk("ov1_sclk_rises", 32'(last_rises), 32'(64));
        busy_mode = 0;
        set_data(16'h8001, 16'h4002, 16'h2004, 16'h1008, 16'h0810, 16'h0420, 16'h0240, 16'h0180);
        push_exp(4);
        f0 = frames;
        wait_frame(f0, 500, "ov_frame2");
        chk("ov_tick_dropped", 32'(conv_last_cyc - conv_prev_cyc), 32'(600));
        chk("ov_sticky", 32'(m_ovr), 32'(1));
        chk("ov2_ncs_cycles", 32'(last_cs), 32'(128));

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
